fofb_link_arbiter: RTL and testbench

- Packet-aware round-robin arbiter for the two-input FOFB read-links stream mux.
- Drives the mux's per-input arbitration-suppress controls so that exactly one link (or none) may enter the mux at a time.
- Holds each grant until a complete packet has been seen on the mux output. TUSER=1 marks the last word of a packet.
- Provides timeout and over-length protection, plus per-link packet counters for the status register file.

---
 rtl/fofb_link_arbiter.sv | 158 +++++++++++++++
 tb/tb_fofb_link_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fofb_link_arbiter.sv
// fofb_link_arbiter: packet-aware round-robin grant control for the two-link FOFB
// read-links stream mux. Drives the mux's per-input arbitration-suppress controls
// and holds each grant until an end-of-packet beat is seen on the mux output.
module fofb_link_arbiter #(
   parameter int MAX_LEN    = 64,
   parameter int TIMEOUT    = 255,
   parameter int GAP_CYCLES = 2,
   parameter int CW         = 16
) (
   input  logic          aclk,
   input  logic          reset,
   input  logic [1:0]    enable,
   input  logic          clear_counters,
   input  logic          s00_tvalid,
   input  logic          s01_tvalid,
   input  logic          m00_tvalid,
   input  logic          m00_tready,
   input  logic          m00_tuser,
   output logic          s00_arb_req_suppress,
   output logic          s01_arb_req_suppress,
   output logic [1:0]    grant,
   output logic          busy,
   output logic [CW-1:0] pkt_count0,
   output logic [CW-1:0] pkt_count1,
   output logic [7:0]    timeout_count,
   output logic          overlen_flag
);

   localparam int BW = $clog2(MAX_LEN + 1);
   localparam int IW = $clog2(TIMEOUT + 1);
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   localparam logic [BW-1:0] BEAT_LAST  = BW'(MAX_LEN - 1);
   localparam logic [IW-1:0] IDLE_LIMIT = IW'(TIMEOUT);
   localparam logic [GW-1:0] GAP_LAST   = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2,
      GAP    = 2'd3
   } state_t;

   state_t        state, state_nxt;
   logic [BW-1:0] beat_cnt, beat_nxt;
   logic [IW-1:0] idle_cnt, idle_nxt;
   logic [GW-1:0] gap_cnt, gap_nxt;
   logic          last_served, last_nxt;
   logic          fire, req0, req1, cur, rel;
   logic [1:0]    pkt_done;
   logic          overlen_evt, timeout_evt;

   // Saturating increment for the 8-bit timeout counter.
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign fire = m00_tvalid & m00_tready;
   assign req0 = s00_tvalid & enable[0];
   assign req1 = s01_tvalid & enable[1];
   assign cur  = (state == GRANT1);
   assign busy = (state != IDLE);

   // Next-state logic: arbitration in IDLE, packet tracking while granted, drain gap.
   always_comb begin
      state_nxt   = state;
      beat_nxt    = beat_cnt;
      idle_nxt    = idle_cnt;
      gap_nxt     = gap_cnt;
      last_nxt    = last_served;
      rel         = 1'b0;
      pkt_done    = 2'b00;
      overlen_evt = 1'b0;
      timeout_evt = 1'b0;
      case (state)
         IDLE: begin
            beat_nxt = '0;
            idle_nxt = '0;
            // On a tie the link that was not served last wins.
            if (req0 && (!req1 || last_served)) begin
               state_nxt = GRANT0;
            end else if (req1) begin
               state_nxt = GRANT1;
            end
         end
         GRANT0, GRANT1: begin
            if (fire) begin
               beat_nxt = beat_cnt + 1'b1;
               idle_nxt = '0;
            end else begin
               idle_nxt = idle_cnt + 1'b1;
            end
            if (fire && m00_tuser) begin
               pkt_done[cur] = 1'b1;
               rel           = 1'b1;
            end else if (fire && (beat_cnt == BEAT_LAST)) begin
               overlen_evt = 1'b1;
               rel         = 1'b1;
            end else if (!fire && (idle_cnt == IDLE_LIMIT)) begin
               timeout_evt = 1'b1;
               rel         = 1'b1;
            end
            if (rel) begin
               last_nxt  = cur;
               gap_nxt   = '0;
               state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
            end
         end
         GAP: begin
            gap_nxt = gap_cnt + 1'b1;
            if (gap_cnt == GAP_LAST) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register; grant and suppress are registered from the next state so
   // they change on the same edge as the FSM.
   always_ff @(posedge aclk) begin
      if (reset) begin
         state                <= IDLE;
         beat_cnt             <= '0;
         idle_cnt             <= '0;
         gap_cnt              <= '0;
         last_served          <= 1'b1;
         grant                <= 2'b00;
         s00_arb_req_suppress <= 1'b1;
         s01_arb_req_suppress <= 1'b1;
      end else begin
         state                <= state_nxt;
         beat_cnt             <= beat_nxt;
         idle_cnt             <= idle_nxt;
         gap_cnt              <= gap_nxt;
         last_served          <= last_nxt;
         grant                <= {state_nxt == GRANT1, state_nxt == GRANT0};
         s00_arb_req_suppress <= (state_nxt != GRANT0);
         s01_arb_req_suppress <= (state_nxt != GRANT1);
      end
   end

   // Status counters and sticky flag; a clear in the same cycle as an event wins.
   always_ff @(posedge aclk) begin
      if (reset || clear_counters) begin
         pkt_count0    <= '0;
         pkt_count1    <= '0;
         timeout_count <= '0;
         overlen_flag  <= 1'b0;
      end else begin
         if (pkt_done[0]) pkt_count0 <= pkt_count0 + 1'b1;
         if (pkt_done[1]) pkt_count1 <= pkt_count1 + 1'b1;
         if (timeout_evt) timeout_count <= sat_inc(timeout_count);
         if (overlen_evt) overlen_flag <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fofb_link_arbiter.sv
// Testbench for fofb_link_arbiter: vector table, directed corner sequences and
// randomized traffic against a behavioural reference model.
module tb_fofb_link_arbiter;

   localparam int MAX_LEN = 64;
   localparam int TIMEOUT = 255;
   localparam int GAP     = 2;

   logic       aclk = 1'b0;
   logic       rst = 1'b1, clr = 1'b0;
   logic [1:0] en = 2'b11;
   logic       v0 = 1'b0, v1 = 1'b0, mv = 1'b0, mr = 1'b1, mu = 1'b0;

   logic        sup0, sup1, busy, ovf;
   logic [1:0]  grant;
   logic [15:0] pc0, pc1;
   logic [7:0]  tc;

   logic        sx_sup0, sx_sup1, sx_busy, sx_ovf;
   logic [1:0]  sx_grant;
   logic [15:0] sx_pc0, sx_pc1;
   logic [7:0]  sx_tc;

   int n_vec = 0;
   int n_miss = 0;

   always #5 aclk = ~aclk;

   fofb_link_arbiter dut (
      .aclk(aclk), .reset(rst), .enable(en), .clear_counters(clr),
      .s00_tvalid(v0), .s01_tvalid(v1),
      .m00_tvalid(mv), .m00_tready(mr), .m00_tuser(mu),
      .s00_arb_req_suppress(sup0), .s01_arb_req_suppress(sup1),
      .grant(grant), .busy(busy), .pkt_count0(pc0), .pkt_count1(pc1),
      .timeout_count(tc), .overlen_flag(ovf)
   );

   // Small instance: short timeout, no drain gap.
   fofb_link_arbiter #(.MAX_LEN(4), .TIMEOUT(3), .GAP_CYCLES(0), .CW(16)) dut_s (
      .aclk(aclk), .reset(rst), .enable(en), .clear_counters(clr),
      .s00_tvalid(v0), .s01_tvalid(v1),
      .m00_tvalid(mv), .m00_tready(mr), .m00_tuser(mu),
      .s00_arb_req_suppress(sx_sup0), .s01_arb_req_suppress(sx_sup1),
      .grant(sx_grant), .busy(sx_busy), .pkt_count0(sx_pc0), .pkt_count1(sx_pc1),
      .timeout_count(sx_tc), .overlen_flag(sx_ovf)
   );

   // Reference model: owner of the mux (-1 none), words and quiet cycles in the
   // current packet, remaining drain cycles, last served link, status values.
   int          m_owner = -1, m_words = 0, m_quiet = 0, m_cool = 0, m_last = 1;
   logic [15:0] m_pc0 = '0, m_pc1 = '0;
   int          m_tc = 0;
   logic        m_ov = 1'b0;

   task automatic model_update();
      logic fire, r0, r1, ov_e, to_e;
      int   done;
      fire = mv && mr;
      r0 = v0 && en[0];
      r1 = v1 && en[1];
      ov_e = 1'b0; to_e = 1'b0; done = -1;
      if (rst) begin
         m_owner = -1; m_cool = 0; m_last = 1; m_words = 0; m_quiet = 0;
         m_pc0 = '0; m_pc1 = '0; m_tc = 0; m_ov = 1'b0;
         return;
      end
      if (m_owner >= 0) begin
         if (fire) begin
            m_quiet = 0;
            m_words = m_words + 1;
            if (mu) done = m_owner;
            else if (m_words == MAX_LEN) ov_e = 1'b1;
         end else if (m_quiet == TIMEOUT) begin
            to_e = 1'b1;
         end else begin
            m_quiet = m_quiet + 1;
         end
         if (done >= 0 || ov_e || to_e) begin
            m_last = m_owner;
            m_owner = -1;
            m_cool = GAP;
         end
      end else if (m_cool > 0) begin
         m_cool = m_cool - 1;
      end else if (r0 || r1) begin
         m_owner = (r0 && r1) ? 1 - m_last : (r0 ? 0 : 1);
         m_words = 0;
         m_quiet = 0;
      end
      if (clr) begin
         m_pc0 = '0; m_pc1 = '0; m_tc = 0; m_ov = 1'b0;
      end else begin
         if (done == 0) m_pc0 = m_pc0 + 16'd1;
         if (done == 1) m_pc1 = m_pc1 + 16'd1;
         if (to_e && m_tc < 255) m_tc = m_tc + 1;
         if (ov_e) m_ov = 1'b1;
      end
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_check();
      logic [1:0]  g;
      logic        b;
      logic [63:0] act, exp;
      g = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
      b = (m_owner >= 0) || (m_cool > 0);
      act = {18'd0, sup1, sup0, grant, busy, pc0, pc1, tc, ovf};
      exp = {18'd0, ~g[1], ~g[0], g, b, m_pc0, m_pc1, 8'(m_tc), m_ov};
      check("model", act, exp);
   endtask

   // One clock: DUT and model advance on the same edge, outputs sampled 1 time unit later.
   task automatic step();
      @(posedge aclk);
      model_update();
      #1;
      model_check();
   endtask

   task automatic do_reset();
      rst = 1'b1; clr = 1'b0; en = 2'b11; v0 = 1'b0; v1 = 1'b0;
      mv = 1'b0; mr = 1'b1; mu = 1'b0;
      step();
      rst = 1'b0;
   endtask

   task automatic wait_grant(input string name);
      int n;
      n = 0;
      mv = 1'b0;
      while (grant == 2'b00 && n < 20) begin
         step();
         n++;
      end
      if (grant == 2'b00) check({name, "_grant_timeout"}, 64'(n), 64'd0);
   endtask

   typedef struct {
      logic       rst;
      logic [1:0] en;
      logic       clr, v0, v1, mv, mu;
      logic [1:0] g;
      logic       busy;
      logic [15:0] pc0, pc1;
   } vec_t;

   vec_t tbl[19];

   initial begin
      int held, zeros;
      logic [1:0] want;

      // rst en clr v0 v1 mv mu | grant busy pc0 pc1
      tbl[0]  = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 16'd0, 16'd0};
      tbl[1]  = '{1'b0, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 16'd0, 16'd0};
      tbl[2]  = '{1'b0, 2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 16'd0, 16'd0};
      tbl[3]  = '{1'b0, 2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 16'd0, 16'd0};
      tbl[4]  = '{1'b0, 2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 16'd0, 16'd0};
      tbl[5]  = '{1'b0, 2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 16'd1, 16'd0};
      tbl[6]  = '{1'b0, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 16'd1, 16'd0};
      tbl[7]  = '{1'b0, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 16'd1, 16'd0};
      tbl[8]  = '{1'b0, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 16'd1, 16'd0};
      tbl[9]  = '{1'b0, 2'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 16'd2, 16'd0};
      tbl[10] = '{1'b0, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 16'd2, 16'd0};
      tbl[11] = '{1'b0, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 16'd2, 16'd0};
      tbl[12] = '{1'b0, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 16'd2, 16'd0};
      tbl[13] = '{1'b0, 2'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 16'd2, 16'd1};
      tbl[14] = '{1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 16'd0, 16'd0};
      tbl[15] = '{1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 16'd0, 16'd0};
      tbl[16] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 16'd0, 16'd0};
      tbl[17] = '{1'b0, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 16'd0, 16'd0};
      tbl[18] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 16'd1, 16'd0};

      mr = 1'b1;
      for (int i = 0; i < 19; i++) begin
         rst = tbl[i].rst; en = tbl[i].en; clr = tbl[i].clr;
         v0 = tbl[i].v0; v1 = tbl[i].v1; mv = tbl[i].mv; mu = tbl[i].mu;
         step();
         check($sformatf("table_%0d", i),
               {21'd0, sup1, sup0, grant, busy, pc0, pc1},
               {21'd0, ~tbl[i].g[1], ~tbl[i].g[0], tbl[i].g, tbl[i].busy, tbl[i].pc0, tbl[i].pc1});
      end

      // Single link, three 4-word packets; grant gap is the drain time plus the arbitration cycle.
      do_reset();
      v0 = 1'b1;
      step();
      check("t1_first_latency", 64'(grant), 64'd1);
      for (int p = 0; p < 3; p++) begin
         for (int k = 0; k < 4; k++) begin
            mv = 1'b1; mu = (k == 3); step();
         end
         mv = 1'b0; mu = 1'b0;
         check("t1_release", 64'({sup0, grant}), 64'({1'b1, 2'b00}));
         zeros = 1;
         while (grant == 2'b00 && zeros < 20) begin step(); if (grant == 2'b00) zeros++; end
         check("t1_gap_len", 64'(zeros), 64'(GAP + 1));
      end
      check("t1_counts", 64'({pc0, pc1}), 64'({16'd3, 16'd0}));

      // Both links continuously requesting: strict alternation.
      do_reset();
      v0 = 1'b1; v1 = 1'b1;
      for (int p = 0; p < 8; p++) begin
         wait_grant("t2");
         want = (p % 2 == 0) ? 2'b01 : 2'b10;
         check($sformatf("t2_alt_%0d", p), 64'(grant), 64'(want));
         for (int k = 0; k < 4; k++) begin
            mv = 1'b1; mu = (k == 3); step();
         end
         mv = 1'b0; mu = 1'b0;
      end
      check("t2_counts", 64'({pc0, pc1}), 64'({16'd4, 16'd4}));

      // Timeout with no output beats, then the waiting link is served.
      do_reset();
      v0 = 1'b1;
      step();
      v1 = 1'b1;
      held = 1;
      while (grant == 2'b01 && held < 400) begin step(); if (grant == 2'b01) held++; end
      check("t3_hold_cycles", 64'(held), 64'(TIMEOUT + 1));
      check("t3_counts", 64'({tc, pc0}), 64'({8'd1, 16'd0}));
      wait_grant("t3");
      check("t3_next_grant", 64'(grant), 64'd2);

      // Over-length packet, sticky flag until cleared.
      do_reset();
      v0 = 1'b1;
      step();
      v0 = 1'b0;
      held = 0;
      for (int k = 0; k < 70; k++) begin
         mv = 1'b1; mu = 1'b0; step();
         if (k < 64 && grant == 2'b01) held++;
      end
      mv = 1'b0;
      check("t4_beats_granted", 64'(held), 64'(MAX_LEN - 1));
      check("t4_flag_set", 64'({ovf, pc0}), 64'({1'b1, 16'd0}));
      step(); step();
      check("t4_flag_sticky", 64'(ovf), 64'd1);
      clr = 1'b1; step(); clr = 1'b0;
      check("t4_flag_cleared", 64'(ovf), 64'd0);

      // Clear coinciding with an increment.
      do_reset();
      v0 = 1'b1;
      for (int p = 0; p < 6; p++) begin
         wait_grant("t5");
         mv = 1'b1; mu = 1'b1; clr = (p == 5);
         step();
         mv = 1'b0; mu = 1'b0; clr = 1'b0;
         if (p == 4) check("t5_count5", 64'(pc0), 64'd5);
      end
      check("t5_clear_wins", 64'(pc0), 64'd0);

      // Short-timeout instance: no drain gap, timeout counter saturation.
      do_reset();
      v0 = 1'b1;
      for (int e = 1; e <= 1290; e++) begin
         step();
         if (e == 1 || e == 4 || e == 6)
            check($sformatf("t5s_grant_e%0d", e), 64'({sx_grant, sx_busy, sx_sup0}), 64'({2'b01, 1'b1, 1'b0}));
         if (e == 5)
            check("t5s_gap0_idle", 64'({sx_grant, sx_busy, sx_sup0}), 64'({2'b00, 1'b0, 1'b1}));
         if (e == 1270) check("t5s_tc254", 64'(sx_tc), 64'd254);
         if (e == 1280) check("t5s_tc255", 64'(sx_tc), 64'd255);
         if (e == 1290) check("t5s_tc_sat", 64'(sx_tc), 64'd255);
      end

      // Reset in the middle of a packet.
      do_reset();
      v0 = 1'b1;
      wait_grant("t6");
      mv = 1'b1; mu = 1'b1; step();
      wait_grant("t6b");
      mv = 1'b1; mu = 1'b0; step(); step();
      rst = 1'b1; mv = 1'b0; step();
      check("t6_reset_state", 64'({sup1, sup0, grant, busy, pc0, tc, ovf}),
            64'({1'b1, 1'b1, 2'b00, 1'b0, 16'd0, 8'd0, 1'b0}));
      rst = 1'b0; v0 = 1'b0; mv = 1'b1; mu = 1'b1;
      step(); step();
      check("t6_residual_ignored", 64'({grant, pc0}), 64'({2'b00, 16'd0}));
      mv = 1'b0; mu = 1'b0; v0 = 1'b1;
      step();
      check("t6_fresh_grant", 64'(grant), 64'd1);

      // Randomized traffic against the model.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 999) < 3);
         clr = ($urandom_range(0, 99) < 2);
         en  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
         v0  = ($urandom_range(0, 3) != 0);
         v1  = ($urandom_range(0, 3) != 0);
         mv  = ($urandom_range(0, 9) < 6);
         mr  = ($urandom_range(0, 9) < 8);
         mu  = ($urandom_range(0, 3) == 0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
